// File: rtl/onchip_ram_arbiter.sv
// Two-port Avalon-MM arbiter in front of one single-port on-chip RAM.
// Round-robin on contention, one transaction per cycle, read data one cycle after grant.
module onchip_ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,

    input  logic [ADDR_W-1:0]   s0_address,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_waitrequest,
    output logic                s0_readdatavalid,

    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_waitrequest,
    output logic                s1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,

    output logic                dbg_last_grant
);

    localparam int BE_W = DATA_W / 8;

    // Handshake: a request (read or write high) is accepted in a cycle where its
    // waitrequest is low; the requester must hold it unchanged while waitrequest is high.
    // Read data is qualified by readdatavalid exactly one cycle after acceptance.

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_e;

    last_e last_grant_q, last_grant_d;
    logic  rd_pend_q, rd_pend_d;
    logic  rd_owner_q, rd_owner_d;

    logic req0, req1;
    logic grant0, grant1;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    // Grant and next-state logic for the last_grant FSM and read tracker.
    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        last_grant_d = last_grant_q;
        rd_pend_d    = 1'b0;
        rd_owner_d   = rd_owner_q;

        if (!reset && !freeze) begin
            if (req0 && req1) begin
                if (last_grant_q == LAST0) grant1 = 1'b1;
                else                       grant0 = 1'b1;
            end else if (req0) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end

        if (grant0) begin
            last_grant_d = LAST0;
            rd_pend_d    = ~s0_write;
            rd_owner_d   = 1'b0;
        end else if (grant1) begin
            last_grant_d = LAST1;
            rd_pend_d    = ~s1_write;
            rd_owner_d   = 1'b1;
        end

        // LAST1 after reset so that port 0 wins the first contention.
        if (reset) begin
            last_grant_d = LAST1;
            rd_pend_d    = 1'b0;
            rd_owner_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= LAST1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    always_comb begin
        ram_address    = s0_address;
        ram_writedata  = s0_writedata;
        ram_byteenable = {BE_W{1'b1}};
        ram_write      = 1'b0;
        if (grant1) begin
            ram_address   = s1_address;
            ram_writedata = s1_writedata;
            ram_write     = s1_write;
            if (s1_write) ram_byteenable = s1_byteenable;
        end else if (grant0) begin
            ram_write = s0_write;
            if (s0_write) ram_byteenable = s0_byteenable;
        end
    end

    assign ram_chipselect = grant0 | grant1;
    assign ram_clken      = ~reset;

    assign s0_waitrequest = ~grant0;
    assign s1_waitrequest = ~grant1;

    // Gating with reset drops a response whose grant was immediately followed by reset.
    assign s0_readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
    assign s1_readdatavalid = rd_pend_q &  rd_owner_q & ~reset;

    assign s0_readdata = ram_readdata;
    assign s1_readdata = ram_readdata;

    assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Table-driven bench for onchip_ram_arbiter with a behavioural RAM and a
// read-response scoreboard backed by a shadow memory.
module tb_onchip_ram_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic [8:0]  s0_address, s1_address;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [31:0] s0_writedata, s1_writedata;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_waitrequest, s1_waitrequest;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic [8:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_readdata;
    logic        dbg_last_grant;

    onchip_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable),
        .s0_read(s0_read), .s0_write(s0_write), .s0_writedata(s0_writedata),
        .s0_readdata(s0_readdata), .s0_waitrequest(s0_waitrequest),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
        .s1_readdatavalid(s1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .dbg_last_grant(dbg_last_grant)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural single-port RAM ----------------
    logic [31:0] ram_mem [0:511];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= 32'hA5A5_0000 | i;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            end
            ram_readdata <= ram_mem[ram_address];
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        rst, frz;
        logic        r0, w0;
        logic [8:0]  a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic        r1, w1;
        logic [8:0]  a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic [1:0]  g;    // expected grant: 0 none, 1 port0, 2 port1
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic frz,
                                logic r0, logic w0, logic [8:0] a0, logic [31:0] d0, logic [3:0] b0,
                                logic r1, logic w1, logic [8:0] a1, logic [31:0] d1, logic [3:0] b1,
                                logic [1:0] g);
        vec_t v;
        v.rst = rst; v.frz = frz;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
        v.g = g;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];          // {owner, expected read data}
    logic [31:0] shadow [0:511];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        freeze        = v.frz;
        s0_read       = v.r0;
        s0_write      = v.w0;
        s0_address    = v.a0;
        s0_writedata  = v.d0;
        s0_byteenable = v.b0;
        s1_read       = v.r1;
        s1_write      = v.w1;
        s1_address    = v.a1;
        s1_writedata  = v.d1;
        s1_byteenable = v.b1;
    endtask

    task automatic check_vec(input vec_t v);
        logic        wr;
        logic [8:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [32:0] e;

        wr = (v.g == 2'd1) ? v.w0 : (v.g == 2'd2) ? v.w1 : 1'b0;
        a  = (v.g == 2'd2) ? v.a1 : v.a0;
        d  = (v.g == 2'd2) ? v.d1 : v.d0;
        be = (v.g == 2'd2) ? v.b1 : v.b0;

        chk("s0_waitrequest", s0_waitrequest, v.g != 2'd1);
        chk("s1_waitrequest", s1_waitrequest, v.g != 2'd2);
        chk("ram_chipselect", ram_chipselect, v.g != 2'd0);
        chk("ram_write", ram_write, wr);
        chk("ram_clken", ram_clken, !v.rst);
        if (v.g != 2'd0) begin
            chk("ram_address", ram_address, a);
            chk("ram_byteenable", ram_byteenable, wr ? be : 4'hF);
            if (wr) chk("ram_writedata", ram_writedata, d);
        end

        if (v.rst) begin
            exp_q.delete();
            chk("s0_readdatavalid", s0_readdatavalid, 0);
            chk("s1_readdatavalid", s1_readdatavalid, 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("s0_readdatavalid", s0_readdatavalid, !e[32]);
            chk("s1_readdatavalid", s1_readdatavalid, e[32]);
            chk(e[32] ? "s1_readdata" : "s0_readdata", e[32] ? s1_readdata : s0_readdata, e[31:0]);
        end else begin
            chk("s0_readdatavalid", s0_readdatavalid, 0);
            chk("s1_readdatavalid", s1_readdatavalid, 0);
        end

        if (v.g != 2'd0) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                exp_q.push_back({v.g == 2'd2, shadow[a]});
            end
        end
    endtask

    // ---------------- main ----------------
    initial begin
        vec_t idle;
        for (int i = 0; i < 512; i++) shadow[i] = 32'hA5A5_0000 | i;
        idle = mk(0,0, 0,0,9'h000,0,4'hF, 0,0,9'h000,0,4'hF, 0);
        drive(mk(1,0, 0,0,9'h000,0,4'hF, 0,0,9'h000,0,4'hF, 0));

        // reset state, both ports requesting
        vecs.push_back(mk(1,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 0));
        vecs.push_back(mk(1,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 0));
        // contention alternates starting with port 0 on the first reset-free cycle
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 1));
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 2));
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 1));
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 2));
        vecs.push_back(idle);
        // s0 write top address, s1 reads it back next cycle
        vecs.push_back(mk(0,0, 0,1,9'h1FF,32'hDEADBEEF,4'hF, 0,0,9'h000,0,4'hF, 1));
        vecs.push_back(mk(0,0, 0,0,9'h000,0,4'hF, 1,0,9'h1FF,0,4'hF, 2));
        vecs.push_back(idle);
        // partial byte write over all-ones -> FFFF3344
        vecs.push_back(mk(0,0, 0,0,9'h000,0,4'hF, 0,1,9'h000,32'hFFFFFFFF,4'hF, 2));
        vecs.push_back(mk(0,0, 0,0,9'h000,0,4'hF, 0,1,9'h000,32'h11223344,4'h3, 2));
        vecs.push_back(mk(0,0, 0,0,9'h000,0,4'hF, 1,0,9'h000,0,4'hF, 2));
        vecs.push_back(idle);
        // freeze for three cycles, grant on the first free cycle
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1, 1,0,9'h010,0,4'hF, 0,0,9'h000,0,4'hF, 0));
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 0,0,9'h000,0,4'hF, 1));
        vecs.push_back(idle);
        // read grant killed by reset; port 0 wins the first contention afterwards
        vecs.push_back(mk(0,0, 1,0,9'h020,0,4'hF, 0,0,9'h000,0,4'hF, 1));
        vecs.push_back(mk(1,0, 0,0,9'h000,0,4'hF, 0,0,9'h000,0,4'hF, 0));
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 1));
        vecs.push_back(mk(0,0, 1,0,9'h010,0,4'hF, 1,0,9'h020,0,4'hF, 2));
        vecs.push_back(idle);
        // read+write together acts as a write
        vecs.push_back(mk(0,0, 1,1,9'h005,32'h0000ABCD,4'hF, 0,0,9'h000,0,4'hF, 1));
        vecs.push_back(idle);
        vecs.push_back(mk(0,0, 0,0,9'h000,0,4'hF, 1,0,9'h005,0,4'hF, 2));
        vecs.push_back(idle);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            check_vec(vecs[i]);
        end

        // every queued response must have been consumed
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_ram_arbiter.md
ONCHIP_RAM_ARBITER -- requirements
Module: onchip_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM word-address width (512 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port freeze  in  1  when high, no new grants are issued.
REQ-006 SHALL have ports s0_address / s1_address  in  ADDR_W  requester word address.
REQ-007 SHALL have ports s0_byteenable / s1_byteenable  in  DATA_W/8  write byte lanes.
REQ-008 SHALL have ports s0_read, s0_write / s1_read, s1_write  in  1 each  Avalon-MM request strobes.
REQ-009 SHALL have ports s0_writedata / s1_writedata  in  DATA_W  write data.
REQ-010 SHALL have ports s0_readdata / s1_readdata  out  DATA_W  read data.
REQ-011 SHALL have ports s0_waitrequest / s1_waitrequest  out  1  stall for the requester.
REQ-012 SHALL have ports s0_readdatavalid / s1_readdatavalid  out  1  read data qualifier.
REQ-013 SHALL have ports ram_address (ADDR_W), ram_byteenable (DATA_W/8), ram_writedata (DATA_W), ram_chipselect, ram_write, ram_clken (1 each)  out  single-port RAM drive.
REQ-014 SHALL have port ram_readdata  in  DATA_W  RAM output, valid one cycle after the address is presented.

Function
REQ-015 A port requests when its read or write is high; read and write together on one port SHALL be treated as write only.
REQ-016 Grant SHALL be combinational per cycle: one request -> that port; both -> the port not recorded in last_grant; freeze=1 or reset=1 -> no grant.
REQ-017 last_grant SHALL be a two-state register (LAST0, LAST1) updated to the granted port on every grant; no grant -> unchanged.
REQ-018 sN_waitrequest SHALL equal NOT grantN (high whenever the port is idle or losing).
REQ-019 Granted cycle SHALL drive ram_address/byteenable/writedata from the winner, ram_chipselect=1, ram_write=winner's write; no grant -> ram_chipselect=0, ram_write=0, other ram outputs don't-care.
REQ-020 ram_byteenable SHALL be all-ones for a granted read.
REQ-021 ram_clken SHALL be NOT reset.
REQ-022 A granted read SHALL set rd_pend=1 and rd_owner=port; on the next cycle sN_readdatavalid SHALL be high for rd_owner only, for exactly one cycle.
REQ-023 s0_readdata and s1_readdata SHALL both equal ram_readdata, meaningful only while their readdatavalid is high.
REQ-024 Throughput SHALL be one transaction per cycle; back-to-back reads (same or alternating ports) SHALL each yield readdatavalid exactly one cycle after their grant.
REQ-025 A write SHALL complete in its grant cycle; write-then-read of the same address on consecutive cycles SHALL return the new data.
REQ-026 freeze SHALL block new grants but a read granted the previous cycle SHALL still produce its readdatavalid.

Reset
REQ-027 While reset=1: last_grant=LAST1 (port 0 wins the first contention), rd_pend=0, both readdatavalid=0, both waitrequest=1, ram_chipselect=0, ram_write=0, ram_clken=0.
REQ-028 Reset asserted the cycle after a read grant SHALL suppress that read's readdatavalid; no response is emitted after reset releases.
REQ-029 First grant SHALL be possible on the first cycle with reset=0.

Verification
REQ-030 Reset release, s0 and s1 both read every cycle from 0x010 / 0x020 -> grants alternate s0,s1,s0,...; each readdatavalid one cycle after its grant to the correct port.
REQ-031 s0 writes 0xDEADBEEF to 0x1FF byteenable 0xF, s1 reads 0x1FF next cycle -> s1_readdatavalid with 0xDEADBEEF.
REQ-032 s1 write 0x11223344 byteenable 0x3 over 0xFFFFFFFF at 0x000, then read -> 0xFFFF3344.
REQ-033 freeze held 3 cycles while s0 reads -> s0_waitrequest=1 for 3 cycles, ram_chipselect=0, grant on first cycle after freeze drops.
REQ-034 s0 read granted, reset on next cycle -> s0_readdatavalid stays 0; after release both ports contend -> s0 granted first.
REQ-035 s0 asserts read and write together at 0x005 with 0x0000ABCD -> ram_write=1, RAM updated, no readdatavalid.
